// File: rtl/qeciphy_link_recovery_sequencer_if.sv
// qeciphy_link_recovery_sequencer_if
//   Groups the supervision signals between the link recovery sequencer and
//   whatever observes/drives it (link controller status, software control).
//   slave  : sequencer side (consumes i_*, drives o_*)
//   master : environment side (drives i_*, consumes o_*)
//   Signals:
//     i_enable       sequencer enable
//     i_state[3:0]   link controller state
//     i_ecode[3:0]   link controller error code
//     i_retry_clear  single-cycle pulse, leave GIVE_UP / clear retry count
//     o_link_rst     reset request to the link controller
//     o_busy         backoff or reset-hold in progress
//     o_gave_up      retries exhausted
//     o_retry_cnt    consecutive retries issued
//     o_last_ecode   code of the last fault (4'hF = training timeout)
//     o_fault_total  total fault count (0 unless statistics are built in)
interface qeciphy_link_recovery_sequencer_if #(
    parameter int MAX_RETRIES = 4
);
    localparam int RC_W = $clog2(MAX_RETRIES + 1);

    logic            i_enable;
    logic [3:0]      i_state;
    logic [3:0]      i_ecode;
    logic            i_retry_clear;
    logic            o_link_rst;
    logic            o_busy;
    logic            o_gave_up;
    logic [RC_W-1:0] o_retry_cnt;
    logic [3:0]      o_last_ecode;
    logic [15:0]     o_fault_total;

    modport slave (
        input  i_enable, i_state, i_ecode, i_retry_clear,
        output o_link_rst, o_busy, o_gave_up, o_retry_cnt, o_last_ecode, o_fault_total
    );

    modport master (
        output i_enable, i_state, i_ecode, i_retry_clear,
        input  o_link_rst, o_busy, o_gave_up, o_retry_cnt, o_last_ecode, o_fault_total
    );
endinterface

// File: rtl/qeciphy_link_recovery_sequencer.sv
// qeciphy_link_recovery_sequencer
//   Supervises the QECIPHY link controller. On FAULT_FATAL or a training
//   timeout it waits an exponential backoff, then pulses o_link_rst to the
//   controller. After MAX_RETRIES consecutive failures it parks in GIVE_UP
//   until software pulses i_retry_clear.
//   Ports:
//     axis_clk   single clock
//     axis_rst   synchronous active-high reset
//     bus        qeciphy_link_recovery_sequencer_if.slave (status in, control out)
//   Build option:
//     QECIPHY_RECOVERY_STATS_EN  enables the saturating o_fault_total counter;
//                                otherwise o_fault_total is tied to 0.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_IDLE     | disabled, nothing issued
//   S_WATCH    | monitoring controller state for fault / training timeout
//   S_BACKOFF  | waiting BACKOFF_BASE << retry_cnt cycles
//   S_RESET_HOLD | o_link_rst held high for RST_HOLD_CYCLES cycles
//   S_GIVE_UP  | retries exhausted, waiting for i_retry_clear
module qeciphy_link_recovery_sequencer #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int TRAIN_TIMEOUT   = 1048576,
    parameter int MAX_RETRIES     = 4,
    parameter int BACKOFF_BASE    = 256,
    parameter int CNT_W           = 24
) (
    input  logic                                   axis_clk,
    input  logic                                   axis_rst,
    qeciphy_link_recovery_sequencer_if.slave       bus
);
    localparam int RC_W = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WATCH,
        S_BACKOFF,
        S_RESET_HOLD,
        S_GIVE_UP
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  timer_q;
    logic [1:0]        mask_q;
    logic [RC_W-1:0]   retry_cnt_q;
    logic [3:0]        last_ecode_q;
    logic              link_rst_q;
    logic              busy_q;
    logic              gave_up_q;

    logic              st_fatal;
    logic              st_training;
    logic              st_quiet;
    logic              timeout;
    logic              fault;
    logic [CNT_W-1:0]  backoff_len;

    assign st_fatal    = (bus.i_state == 4'd5);
    assign st_training = (bus.i_state == 4'd1) || (bus.i_state == 4'd2) || (bus.i_state == 4'd3);
    assign st_quiet    = (bus.i_state == 4'd0) || (bus.i_state == 4'd4) ||
                         (bus.i_state == 4'd6) || (bus.i_state == 4'd7);
    assign timeout     = (timer_q == CNT_W'(TRAIN_TIMEOUT - 1));
    // Disable wins over fault, and the post-reset mask hides stale controller state.
    assign fault       = bus.i_enable && (state_q == S_WATCH) && (mask_q == 2'd0) &&
                         (st_fatal || timeout);
    assign backoff_len = CNT_W'(BACKOFF_BASE) << retry_cnt_q;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            mask_q       <= 2'd0;
            retry_cnt_q  <= '0;
            last_ecode_q <= 4'h0;
            link_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
            gave_up_q    <= 1'b0;
        end else if (!bus.i_enable) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            mask_q      <= 2'd0;
            retry_cnt_q <= '0;
            link_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            gave_up_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_WATCH;
                    timer_q <= '0;
                end
                S_WATCH: begin
                    if (mask_q != 2'd0) mask_q <= mask_q - 2'd1;
                    if (fault) begin
                        last_ecode_q <= st_fatal ? bus.i_ecode : 4'hF;
                        timer_q      <= '0;
                        // Retry decision uses the count before any same-cycle clear.
                        if (retry_cnt_q < RC_W'(MAX_RETRIES)) begin
                            state_q <= S_BACKOFF;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q   <= S_GIVE_UP;
                            gave_up_q <= 1'b1;
                        end
                    end else begin
                        if (st_quiet)
                            timer_q <= '0;
                        else if (st_training && !timeout)
                            timer_q <= timer_q + 1'b1;
                        if ((bus.i_state == 4'd4) || bus.i_retry_clear)
                            retry_cnt_q <= '0;
                    end
                end
                S_BACKOFF: begin
                    if (timer_q == backoff_len - 1'b1) begin
                        state_q     <= S_RESET_HOLD;
                        timer_q     <= '0;
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                        link_rst_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RESET_HOLD: begin
                    if (timer_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                        state_q    <= S_WATCH;
                        timer_q    <= '0;
                        mask_q     <= 2'd2;
                        link_rst_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_GIVE_UP: begin
                    if (bus.i_retry_clear) begin
                        state_q     <= S_RESET_HOLD;
                        timer_q     <= '0;
                        retry_cnt_q <= '0;
                        gave_up_q   <= 1'b0;
                        link_rst_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign bus.o_link_rst   = link_rst_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_gave_up    = gave_up_q;
    assign bus.o_retry_cnt  = retry_cnt_q;
    assign bus.o_last_ecode = last_ecode_q;

`ifdef QECIPHY_RECOVERY_STATS_EN
    logic [15:0] fault_total_q;

    always_ff @(posedge axis_clk) begin
        if (axis_rst)
            fault_total_q <= 16'h0000;
        else if (fault && (fault_total_q != 16'hFFFF))
            fault_total_q <= fault_total_q + 16'h0001;
    end

    assign bus.o_fault_total = fault_total_q;
`else
    assign bus.o_fault_total = 16'h0000;
`endif

endmodule

// File: tb/tb_qeciphy_link_recovery_sequencer.sv
module tb_qeciphy_link_recovery_sequencer;
    localparam int RST_HOLD_CYCLES = 4;
    localparam int TRAIN_TIMEOUT   = 100;
    localparam int MAX_RETRIES     = 2;
    localparam int BACKOFF_BASE    = 8;
    localparam int CNT_W           = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qeciphy_link_recovery_sequencer_if #(.MAX_RETRIES(MAX_RETRIES)) bus ();

    qeciphy_link_recovery_sequencer #(
        .RST_HOLD_CYCLES(RST_HOLD_CYCLES),
        .TRAIN_TIMEOUT  (TRAIN_TIMEOUT),
        .MAX_RETRIES    (MAX_RETRIES),
        .BACKOFF_BASE   (BACKOFF_BASE),
        .CNT_W          (CNT_W)
    ) dut (
        .axis_clk(clk),
        .axis_rst(rst),
        .bus     (bus)
    );

    typedef struct {
        logic       en;
        logic [3:0] st;
        logic [3:0] ec;
        logic       clr;
        logic       lr;
        logic       bz;
        logic       gu;
        logic [1:0] rc;
        logic [3:0] le;
        logic [15:0] ft;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   faults_model = 0;

    function automatic logic [15:0] exp_ft(input int n);
`ifdef QECIPHY_RECOVERY_STATS_EN
        return 16'(n);
`else
        return 16'h0000;
`endif
    endfunction

    // flt marks the row on which the bench expects a fault to be recorded.
    function automatic void add(input logic en, input logic [3:0] st, input logic [3:0] ec,
                                input logic clr, input logic flt, input logic lr, input logic bz,
                                input logic gu, input logic [1:0] rc, input logic [3:0] le);
        vec_t v;
        if (flt) faults_model++;
        v.en = en; v.st = st; v.ec = ec; v.clr = clr;
        v.lr = lr; v.bz = bz; v.gu = gu; v.rc = rc; v.le = le;
        v.ft = exp_ft(faults_model);
        vecs.push_back(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs;
        return {7'd0, bus.o_link_rst, bus.o_busy, bus.o_gave_up, bus.o_retry_cnt,
                bus.o_last_ecode, bus.o_fault_total};
    endfunction

    task automatic drive(input logic en, input logic [3:0] st, input logic [3:0] ec, input logic clr);
        bus.i_enable = en; bus.i_state = st; bus.i_ecode = ec; bus.i_retry_clear = clr;
    endtask

    initial begin
        int n;
        // Scenario 1: FAULT_FATAL, 8-cycle backoff, 4-cycle reset
        add(1,0,0,0,0, 0,0,0,0,0);
        add(1,5,2,0,1, 0,1,0,0,2);
        for (int i = 0; i < 7; i++) add(1,0,0,0,0, 0,1,0,0,2);
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, 1,1,0,1,2);
        add(1,0,0,0,0, 0,0,0,1,2);
        // Scenario 4: LINK_READY clears retries; SLEEP and interrupted training never time out
        add(1,4,0,0,0, 0,0,0,0,2);
        for (int i = 0; i < 1000; i++) add(1,6,0,0,0, 0,0,0,0,2);
        for (int i = 0; i < 60; i++) add(1,2,0,0,0, 0,0,0,0,2);
        add(1,6,0,0,0, 0,0,0,0,2);
        for (int i = 0; i < 60; i++) add(1,2,0,0,0, 0,0,0,0,2);
        add(1,6,0,0,0, 0,0,0,0,2);
        // Scenario 2: training timeout on the 100th training cycle
        for (int i = 0; i < 99; i++) add(1,2,0,0,0, 0,0,0,0,2);
        add(1,2,0,0,1, 0,1,0,0,4'hF);
        for (int i = 0; i < 7; i++) add(1,0,0,0,0, 0,1,0,0,4'hF);
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, 1,1,0,1,4'hF);
        add(1,0,0,0,0, 0,0,0,1,4'hF);
        add(1,0,0,1,0, 0,0,0,0,4'hF);
        add(1,0,0,0,0, 0,0,0,0,4'hF);
        // Scenario 3: three faults, 8 then 16 backoff, then GIVE_UP
        add(1,5,3,0,1, 0,1,0,0,3);
        for (int i = 0; i < 7; i++) add(1,0,0,0,0, 0,1,0,0,3);
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, 1,1,0,1,3);
        add(1,0,0,0,0, 0,0,0,1,3);
        for (int i = 0; i < 2; i++) add(1,5,3,0,0, 0,0,0,1,3);
        add(1,5,7,0,1, 0,1,0,1,7);
        for (int i = 0; i < 15; i++) add(1,0,0,(i == 5),0, 0,1,0,1,7);
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, 1,1,0,2,7);
        add(1,0,0,0,0, 0,0,0,2,7);
        for (int i = 0; i < 2; i++) add(1,0,0,0,0, 0,0,0,2,7);
        add(1,5,9,1,1, 0,0,1,2,9);
        for (int i = 0; i < 3; i++) add(1,5,1,0,0, 0,0,1,2,9);
        add(1,0,0,1,0, 1,1,0,0,9);
        for (int i = 0; i < 3; i++) add(1,0,0,0,0, 1,1,0,0,9);
        add(1,0,0,0,0, 0,0,0,0,9);
        for (int i = 0; i < 2; i++) add(1,0,0,0,0, 0,0,0,0,9);

        // Reset: outputs zero even with a fault presented
        drive(1, 4'd5, 4'd3, 1'b0);
        rst = 1'b1;
        tick; tick; tick;
        chk("reset_outputs", outs(), 32'd0);
        drive(0, 4'd0, 4'd0, 1'b0);
        tick;
        rst = 1'b0;
        tick;
        chk("idle_disabled", outs(), 32'd0);

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].st, vecs[k].ec, vecs[k].clr);
            tick;
            chk($sformatf("vec%0d", k), outs(),
                {7'd0, vecs[k].lr, vecs[k].bz, vecs[k].gu, vecs[k].rc, vecs[k].le, vecs[k].ft});
        end
        drive(1, 4'd0, 4'd0, 1'b0);

        // Scenario 5: enable dropped on the second RESET_HOLD cycle
        drive(1, 4'd5, 4'd4, 1'b0);
        tick;
        chk("s5_fault_busy", {bus.o_busy, bus.o_last_ecode}, {1'b1, 4'h4});
        drive(1, 4'd0, 4'd0, 1'b0);
        n = 0;
        while (!bus.o_link_rst && n < 50) begin
            tick;
            n++;
        end
        chk("s5_backoff_len", 32'(n), 32'd8);
        chk("s5_rst_retry", {bus.o_link_rst, 2'(bus.o_retry_cnt)}, {1'b1, 2'd1});
        tick;
        chk("s5_hold_cycle2", {bus.o_link_rst, bus.o_busy}, 2'b11);
        drive(0, 4'd0, 4'd0, 1'b0);
        tick;
        chk("s5_disable", {bus.o_link_rst, bus.o_busy, bus.o_gave_up, 2'(bus.o_retry_cnt), bus.o_last_ecode},
            {3'b000, 2'd0, 4'h4});
        tick;
        chk("s5_stay_idle", {bus.o_link_rst, bus.o_busy, 2'(bus.o_retry_cnt)}, 4'd0);

        // Synchronous reset clears last_ecode and fault_total
        drive(1, 4'd0, 4'd0, 1'b0);
        tick;
        drive(1, 4'd5, 4'd6, 1'b0);
        tick;
        chk("pre_rst_fault", {bus.o_busy, bus.o_last_ecode, bus.o_fault_total},
            {1'b1, 4'h6, exp_ft(faults_model + 2)});
        rst = 1'b1;
        tick;
        chk("rst_clears_all", outs(), 32'd0);
        rst = 1'b0;
        drive(0, 4'd0, 4'd0, 1'b0);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
